// File: rtl/run_ctrl.sv
// run_ctrl: run/step/halt controller for a small CPU.
//
// Two raw front-panel inputs (a step push-button and a run switch) are
// synchronized and debounced. The debounced run level and a one-cycle pulse on
// each debounced step press drive a three-state controller. That controller
// produces the CPU advance enable.
//
// Ports:
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   btn_step    raw step push-button (async, bouncy)
//   sw_run      raw run switch (async, bouncy)
//   halt        CPU halt request, synchronous level
//   en          advance enable (combinational from state and step_pulse)
//   state       00 STOP, 01 RUN, 10 HALT
//   run_db      debounced sw_run
//   step_pulse  one-cycle pulse per debounced btn_step rising edge

// db_chan: one input channel. It has a 2-flop synchronizer and a
// consecutive-difference debouncer.
//   raw -> db, which follows raw once raw has differed for DbCnt consecutive edges.
module db_chan #(
    parameter int DbBits = 16,
    parameter int DbCnt  = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic db
);
    logic              sync1, sync2;
    logic [DbBits-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            db    <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 == db) begin
                cnt <= '0;
            end else if (cnt == DbBits'(DbCnt - 1)) begin
                // This edge is the DbCnt-th consecutive edge on which the two differ.
                db  <= sync2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module run_ctrl #(
    parameter int DbBits = 16,
    parameter int DbCnt  = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_step,
    input  logic       sw_run,
    input  logic       halt,
    output logic       en,
    output logic [1:0] state,
    output logic       run_db,
    output logic       step_pulse
);
    localparam int NUM_CH = 2;
    localparam int CH_STEP = 0;
    localparam int CH_RUN  = 1;

    typedef enum logic [1:0] {
        ST_STOP = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_t;

    logic [NUM_CH-1:0] raw_in;
    logic [NUM_CH-1:0] db_out;
    logic              step_prev;
    state_t            cur, nxt;

    assign raw_in[CH_STEP] = btn_step;
    assign raw_in[CH_RUN]  = sw_run;

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
            db_chan #(.DbBits(DbBits), .DbCnt(DbCnt)) u_db (
                .clk   (clk),
                .rst_n (rst_n),
                .raw   (raw_in[g]),
                .db    (db_out[g])
            );
        end
    endgenerate

    assign run_db = db_out[CH_RUN];

    // Registered rising-edge detect of the debounced step button.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_prev  <= 1'b0;
            step_pulse <= 1'b0;
        end else begin
            step_prev  <= db_out[CH_STEP];
            step_pulse <= db_out[CH_STEP] & ~step_prev;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cur <= ST_STOP;
        else        cur <= nxt;
    end

    // en comes from state and the registered step pulse, so reset drops it at once.
    // A step pulse in HALT only leaves HALT; it must not advance the CPU.
    always_comb begin
        nxt = cur;
        en  = (cur == ST_RUN) | ((cur == ST_STOP) & step_pulse);
        if (en && halt) begin
            nxt = ST_HALT;
        end else begin
            unique case (cur)
                ST_STOP: if (run_db)     nxt = ST_RUN;
                ST_RUN:  if (!run_db)    nxt = ST_STOP;
                ST_HALT: if (step_pulse) nxt = ST_STOP;
                default: nxt = ST_STOP;
            endcase
        end
    end

    assign state = cur;
endmodule

// File: tb/tb_run_ctrl.sv
module tb_run_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_step = 1'b0;
    logic       sw_run = 1'b0;
    logic       halt = 1'b0;
    logic       en;
    logic [1:0] state;
    logic       run_db;
    logic       step_pulse;

    int checks = 0;
    int errors = 0;

    // Expected output packing: {en, state[1:0], run_db, step_pulse}
    localparam logic [4:0] Z      = 5'b00000; // STOP, idle
    localparam logic [4:0] STP_EN = 5'b10001; // STOP, step pulse, en
    localparam logic [4:0] STP_R  = 5'b00010; // STOP, run_db=1
    localparam logic [4:0] RUN_R  = 5'b10110; // RUN, run_db=1
    localparam logic [4:0] RUN_NR = 5'b10100; // RUN, run_db=0
    localparam logic [4:0] HLT_R  = 5'b01010; // HALT, run_db=1
    localparam logic [4:0] HLT_RP = 5'b01011; // HALT, run_db=1, pulse
    localparam logic [4:0] HLT    = 5'b01000; // HALT
    localparam logic [4:0] HLT_P  = 5'b01001; // HALT, pulse

    logic [4:0] exp_q[$];
    int         cyc_no = 0;

    run_ctrl #(.DbBits(3), .DbCnt(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_step   (btn_step),
        .sw_run     (sw_run),
        .halt       (halt),
        .en         (en),
        .state      (state),
        .run_db     (run_db),
        .step_pulse (step_pulse)
    );

    always #5 clk = ~clk;

    // Monitor: outputs are presented every cycle; compare one expectation per cycle.
    always @(negedge clk) begin
        logic [4:0] e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {en, state, run_db, step_pulse};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL cyc%0d en/state/run_db/step_pulse: got %b expected %b", cyc_no, a, e);
            end
            cyc_no++;
        end
    end

    // Drive inputs (sampled at the next edge) and queue the expected outputs
    // for the current cycle, then advance one clock.
    task automatic cyc(input logic b, input logic r, input logic h, input logic [4:0] e);
        btn_step = b;
        sw_run   = r;
        halt     = h;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Raise sw_run from STOP and ride it into RUN (12 cycles).
    task automatic enter_run();
        for (int i = 0; i < 12; i++)
            cyc(0, 1, 0, (i < 6) ? Z : (i == 6) ? STP_R : RUN_R);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk); #1;
        // Reset held: all outputs low.
        cyc(0, 0, 0, Z);
        cyc(1, 1, 1, Z);
        rst_n = 1'b1;
        cyc(0, 0, 0, Z);
        cyc(0, 0, 0, Z);

        // Held step press: a single pulse with en, seen after edge 6.
        for (int i = 0; i < 20; i++) cyc(1, 0, 0, (i == 7) ? STP_EN : Z);
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, Z);

        // A 3-high/3-low bounce is shorter than DbCnt, so it is filtered out.
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < 3; i++) cyc(1, 0, 0, Z);
            for (int i = 0; i < 3; i++) cyc(0, 0, 0, Z);
        end
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, Z);

        // The run switch enters RUN, and dropping it returns to STOP 6 edges later.
        enter_run();
        for (int i = 0; i < 10; i++)
            cyc(0, 0, 0, (i < 6) ? RUN_R : (i == 6) ? RUN_NR : Z);

        // RUN, then halt, then HALT with run held; a step goes to STOP, then RUN.
        enter_run();
        cyc(0, 1, 1, RUN_R);
        cyc(0, 1, 1, HLT_R);                      // halt is ignored in HALT
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, HLT_R);
        for (int i = 0; i < 12; i++)
            cyc(1, 1, 0, (i < 7) ? HLT_R : (i == 7) ? HLT_RP : (i == 8) ? STP_R : RUN_R);
        for (int i = 0; i < 10; i++) cyc(0, 1, 0, RUN_R);
        for (int i = 0; i < 10; i++)
            cyc(0, 0, 0, (i < 6) ? RUN_R : (i == 6) ? RUN_NR : Z);

        // STOP with halt held: no effect until the step's en cycle, then HALT.
        for (int i = 0; i < 12; i++) cyc(1, 0, 1, (i < 7) ? Z : (i == 7) ? STP_EN : HLT);
        for (int i = 0; i < 8; i++) cyc(0, 0, 1, HLT);
        for (int i = 0; i < 10; i++) cyc(1, 0, 0, (i < 7) ? HLT : (i == 7) ? HLT_P : Z);
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, Z);

        // A mid-RUN reset pulse between edges drops en/state at once, and the
        // debounce sequence restarts.
        enter_run();
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (en !== 1'b0 || state !== 2'b00) begin
            errors++;
            $display("FAIL async_reset: got en=%b state=%b expected en=0 state=00", en, state);
        end
        #1 rst_n = 1'b1;
        enter_run();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
